// File: rtl/output_switch_pkg.sv
// Shared definitions for the output_switch pin-ownership switch:
// default parameters, FSM state encoding and small state decode helpers.
package output_switch_pkg;

    localparam int unsigned DEF_WIDTH         = 8;
    localparam logic [7:0]  DEF_SAFE_VAL      = 8'hff;
    localparam int unsigned DEF_SYNC_STAGES   = 2;
    localparam int unsigned DEF_STABLE_CYCLES = 4;
    localparam int unsigned DEF_DEAD_CYCLES   = 16;

    localparam logic [1:0] ST_OWN_A     = 2'd0;
    localparam logic [1:0] ST_DEAD_TO_B = 2'd1;
    localparam logic [1:0] ST_OWN_B     = 2'd2;
    localparam logic [1:0] ST_DEAD_TO_A = 2'd3;

    typedef enum logic [1:0] {
        OWN_A     = ST_OWN_A,
        DEAD_TO_B = ST_DEAD_TO_B,
        OWN_B     = ST_OWN_B,
        DEAD_TO_A = ST_DEAD_TO_A
    } state_t;

    function automatic logic is_dead(input state_t s);
        return (s == DEAD_TO_B) || (s == DEAD_TO_A);
    endfunction

    // CPU B is the owner both while it owns the pins and while being switched to.
    function automatic logic owner_of(input state_t s);
        return (s == OWN_B) || (s == DEAD_TO_B);
    endfunction

endpackage

// File: rtl/ctr_filter.sv
// Synchronizes the asynchronous ctr_io select and accepts a change only
// after it has persisted for STABLE_CYCLES synchronized cycles.
module ctr_filter
    import output_switch_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic ctr_io,
    output logic filt_sel
);

    localparam int unsigned     CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_sel;
    logic [CW-1:0]          cnt;

    assign sync_sel = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            cnt      <= '0;
            filt_sel <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ctr_io};
            if (sync_sel == filt_sel) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // the edge on which the count would reach STABLE_CYCLES
                filt_sel <= sync_sel;
                cnt      <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/output_switch.sv
// Glitch-free handover of a shared pin bus between CPU A and CPU B, with the
// pins parked at SAFE_VAL for a fixed dead time on every ownership change.
module output_switch
    import output_switch_pkg::*;
#(
    parameter int unsigned       WIDTH         = DEF_WIDTH,
    parameter logic [WIDTH-1:0]  SAFE_VAL      = WIDTH'(DEF_SAFE_VAL),
    parameter int unsigned       SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int unsigned       STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned       DEAD_CYCLES   = DEF_DEAD_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctr_io,
    input  logic [WIDTH-1:0] out_from_A,
    input  logic [WIDTH-1:0] out_from_B,
    output logic [WIDTH-1:0] output_pin,
    output logic             owner,
    output logic             switching
);

    localparam int unsigned   DW        = $clog2(DEAD_CYCLES + 1);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);

    logic          filt_sel;
    state_t        state, state_nxt;
    logic [DW-1:0] dead_cnt, dead_nxt;

    ctr_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ctr_filter (
        .clk     (clk),
        .rst     (rst),
        .ctr_io  (ctr_io),
        .filt_sel(filt_sel)
    );

    always_comb begin
        state_nxt = state;
        dead_nxt  = dead_cnt;
        unique case (state)
            OWN_A: begin
                if (filt_sel) begin
                    state_nxt = DEAD_TO_B;
                    dead_nxt  = '0;
                end
            end
            OWN_B: begin
                if (!filt_sel) begin
                    state_nxt = DEAD_TO_A;
                    dead_nxt  = '0;
                end
            end
            DEAD_TO_B: begin
                // a reversal restarts the full dead time toward the other CPU
                if (!filt_sel) begin
                    state_nxt = DEAD_TO_A;
                    dead_nxt  = '0;
                end else if (dead_cnt == DEAD_LAST) begin
                    state_nxt = OWN_B;
                    dead_nxt  = '0;
                end else begin
                    dead_nxt = dead_cnt + DW'(1);
                end
            end
            DEAD_TO_A: begin
                if (filt_sel) begin
                    state_nxt = DEAD_TO_B;
                    dead_nxt  = '0;
                end else if (dead_cnt == DEAD_LAST) begin
                    state_nxt = OWN_A;
                    dead_nxt  = '0;
                end else begin
                    dead_nxt = dead_cnt + DW'(1);
                end
            end
            default: begin
                state_nxt = DEAD_TO_A;
                dead_nxt  = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so the pins change on the
    // same edge the FSM enters a state (1-cycle data latency in OWN states).
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DEAD_TO_A;
            dead_cnt   <= '0;
            output_pin <= SAFE_VAL;
            owner      <= 1'b0;
            switching  <= 1'b1;
        end else begin
            state     <= state_nxt;
            dead_cnt  <= dead_nxt;
            owner     <= owner_of(state_nxt);
            switching <= is_dead(state_nxt);
            unique case (state_nxt)
                OWN_A:   output_pin <= out_from_A;
                OWN_B:   output_pin <= out_from_B;
                default: output_pin <= SAFE_VAL;
            endcase
        end
    end

endmodule

// File: tb/tb_output_switch.sv
// Scoreboard bench for output_switch: each driven cycle queues the expected
// {output_pin, owner, switching}; a monitor compares after every clock edge.
module tb_output_switch;

    localparam logic [7:0] SAFE = 8'hff;
    localparam int K_A  = 0;   // A data, owner 0, not switching
    localparam int K_B  = 1;   // B data, owner 1, not switching
    localparam int K_SA = 2;   // SAFE, heading to A
    localparam int K_SB = 3;   // SAFE, heading to B

    typedef struct {
        logic [9:0] val;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ctr_io = 1'b0;
    logic [7:0] out_from_A = '0;
    logic [7:0] out_from_B = '0;
    logic [7:0] output_pin;
    logic       owner;
    logic       switching;

    int    total = 0;
    int    bad   = 0;
    string phase = "init";
    exp_t  exp_q[$];
    exp_t  mon_e;

    always #5 clk = ~clk;

    output_switch #(
        .WIDTH        (8),
        .SAFE_VAL     (8'hff),
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(4),
        .DEAD_CYCLES  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ctr_io    (ctr_io),
        .out_from_A(out_from_A),
        .out_from_B(out_from_B),
        .output_pin(output_pin),
        .owner     (owner),
        .switching (switching)
    );

    // Drive n cycles of the given inputs; expectation applies after the next edge.
    task automatic seg(input logic r, input logic c, input int kind,
                       input int n, input bit rnd);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst    = r;
            ctr_io = c;
            if (rnd) begin
                out_from_A = 8'($urandom);
                out_from_B = 8'($urandom);
            end else begin
                out_from_A = 8'h5a;
                out_from_B = 8'h3c;
            end
            e.name = phase;
            case (kind)
                K_A:     e.val = {out_from_A, 2'b00};
                K_B:     e.val = {out_from_B, 2'b10};
                K_SA:    e.val = {SAFE, 2'b01};
                default: e.val = {SAFE, 2'b11};
            endcase
            exp_q.push_back(e);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                total++;
                if ({output_pin, owner, switching} !== mon_e.val) begin
                    bad++;
                    $display("FAIL %s t=%0t got pin=%h owner=%b sw=%b, want pin=%h owner=%b sw=%b",
                             mon_e.name, $time, output_pin, owner, switching,
                             mon_e.val[9:2], mon_e.val[1], mon_e.val[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        phase = "reset";
        seg(1'b1, 1'b0, K_SA, 2, 1'b0);
        phase = "reset_dead";
        seg(1'b0, 1'b0, K_SA, 15, 1'b0);
        phase = "own_a_first";
        seg(1'b0, 1'b0, K_A, 1, 1'b0);

        phase = "own_a_data";
        seg(1'b0, 1'b0, K_A, 8, 1'b1);

        phase = "glitch_3cyc";
        seg(1'b0, 1'b1, K_A, 3, 1'b1);
        seg(1'b0, 1'b0, K_A, 10, 1'b1);

        // first SAFE 7 cycles after the sample edge, 16 SAFE, then B data
        phase = "a_to_b";
        seg(1'b0, 1'b1, K_A, 6, 1'b0);
        seg(1'b0, 1'b1, K_SB, 16, 1'b0);
        seg(1'b0, 1'b1, K_B, 1, 1'b0);

        phase = "own_b_data";
        seg(1'b0, 1'b1, K_B, 8, 1'b1);

        phase = "b_to_a";
        seg(1'b0, 1'b0, K_B, 6, 1'b1);
        seg(1'b0, 1'b0, K_SA, 16, 1'b1);
        seg(1'b0, 1'b0, K_A, 4, 1'b1);

        // ctr_io drops 5 cycles into DEAD_TO_B; filter accepts 5 edges later
        phase = "reversal";
        seg(1'b0, 1'b1, K_A, 6, 1'b1);
        seg(1'b0, 1'b1, K_SB, 5, 1'b1);
        seg(1'b0, 1'b0, K_SB, 6, 1'b1);
        seg(1'b0, 1'b0, K_SA, 16, 1'b1);
        seg(1'b0, 1'b0, K_A, 4, 1'b1);

        phase = "rst_mid_dead";
        seg(1'b0, 1'b1, K_A, 6, 1'b1);
        seg(1'b0, 1'b1, K_SB, 9, 1'b1);
        seg(1'b1, 1'b0, K_SA, 1, 1'b1);
        seg(1'b0, 1'b0, K_SA, 15, 1'b1);
        seg(1'b0, 1'b0, K_A, 4, 1'b1);

        phase = "rst_mid_own";
        seg(1'b1, 1'b0, K_SA, 1, 1'b1);
        seg(1'b0, 1'b0, K_SA, 15, 1'b1);
        seg(1'b0, 1'b0, K_A, 3, 1'b1);

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/output_switch.md
OUTPUT_SWITCH -- requirements
Module: output_switch

Interface
REQ-001 Parameter WIDTH, default 8: pin bus width.
REQ-002 Parameter SAFE_VAL, default 8'hff: pin value while no CPU owns the pins.
REQ-003 Parameter SYNC_STAGES, default 2: ctr_io synchronizer depth, minimum 2.
REQ-004 Parameter STABLE_CYCLES, default 4: consecutive cycles a synchronized ctr_io change must persist before acceptance, minimum 1.
REQ-005 Parameter DEAD_CYCLES, default 16: cycles pins are held at SAFE_VAL during an ownership change, minimum 1.
REQ-006 clk  input  1  single clock; all logic on posedge clk.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 ctr_io  input  1  asynchronous select; 0 = CPU A owns pins, 1 = CPU B.
REQ-009 out_from_A  input  WIDTH  pin drive from CPU A.
REQ-010 out_from_B  input  WIDTH  pin drive from CPU B.
REQ-011 output_pin  output  WIDTH  registered drive to physical pins.
REQ-012 owner  output  1  registered; 0 = A, 1 = B; the CPU currently owning the pins, or being switched to.
REQ-013 switching  output  1  registered; 1 while in a dead-time state.

Function
REQ-014 ctr_io SHALL pass through a SYNC_STAGES flop chain; only the chain output (sync_sel) is used.
REQ-015 Filter: counter increments each cycle sync_sel != filt_sel and clears when they are equal; on the edge where the counter would reach STABLE_CYCLES, filt_sel <= sync_sel and the counter clears.
REQ-016 FSM states: OWN_A, DEAD_TO_B, OWN_B, DEAD_TO_A.
REQ-017 OWN_A -> DEAD_TO_B when filt_sel==1; OWN_B -> DEAD_TO_A when filt_sel==0; otherwise hold.
REQ-018 DEAD_TO_x: dead counter clears on entry and increments each cycle; after exactly DEAD_CYCLES cycles in the state, go to OWN_x.
REQ-019 Reversal mid-dead: in DEAD_TO_B with filt_sel==0, go to DEAD_TO_A with the dead counter cleared (and vice versa); the full dead time restarts.
REQ-020 output_pin is registered from the current state: OWN_A -> out_from_A, OWN_B -> out_from_B, DEAD_* -> SAFE_VAL.
REQ-021 Data latency in an OWN state is 1 cycle from out_from_x to output_pin.
REQ-022 Control latency from ctr_io sample edge to first SAFE_VAL on output_pin = SYNC_STAGES + STABLE_CYCLES + 1 (7 at defaults).
REQ-023 output_pin SHALL equal SAFE_VAL for exactly DEAD_CYCLES consecutive cycles between the last A-data cycle and the first B-data cycle, and vice versa; A and B data are never adjacent.
REQ-024 owner = 1 in OWN_B/DEAD_TO_B, 0 otherwise; switching = 1 in DEAD_* states; both registered alongside output_pin.
REQ-025 ctr_io pulses shorter than STABLE_CYCLES synchronized cycles SHALL cause no state change.

Reset
REQ-026 While rst is high: state = DEAD_TO_A; dead and filter counters = 0; sync chain and filt_sel = 0; output_pin = SAFE_VAL; owner = 0; switching = 1.
REQ-027 After rst deasserts, pins stay SAFE_VAL for DEAD_CYCLES cycles, then follow the selected CPU per REQ-017..019.
REQ-028 rst asserted mid-dead or mid-ownership overrides all inputs on that edge.

Structure
REQ-029 Package output_switch_pkg holds the state enum, state encoding, and default parameter constants.
REQ-030 Sub-module ctr_filter SHALL implement REQ-014/015 (synchronizer plus stability counter) and output filt_sel.

Verification
REQ-031 Reset, ctr_io=0, out_from_A=8'h5a -> output_pin=8'hff for 16 cycles, then 8'h5a; owner=0, switching 1 -> 0.
REQ-032 In OWN_A, ctr_io 0->1 held, out_from_B=8'h3c -> first 8'hff 7 cycles after the sample edge, 16 cycles of 8'hff, then 8'h3c; owner=1.
REQ-033 In OWN_A, ctr_io high for 3 cycles only -> output_pin stays out_from_A, switching stays 0.
REQ-034 ctr_io 0->1, then back to 0 five cycles after DEAD_TO_B entry -> DEAD_TO_A, dead counter restarts; 8'hff held continuously, then A data; no B data ever appears.
REQ-035 rst pulsed at dead-counter value 8 of DEAD_TO_B -> next cycle DEAD_TO_A, owner=0, output_pin=8'hff for a full 16 cycles.
REQ-036 Randomized out_from_A/out_from_B in OWN states -> output_pin equals the owner's input delayed by exactly 1 cycle.
